// File: rtl/sdram_arb_pkg.sv
// Shared types, widths and the round-robin/priority winner function used by
// the SDRAM request arbiter and the sprite-fetch scheduler.
package sdram_arb_pkg;

   localparam int MAX_NREQ = 8;
   localparam int GW       = 3;
   localparam int DW       = 16;
   localparam int DSW      = 2;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      HOLD
   } arb_state_t;

   // Walk downward from the farthest candidate so the nearest valid index after
   // 'last' overwrites the rest; k == nreq lands back on 'last' as the fallback.
   function automatic logic [GW-1:0] rr_pick(
      input logic [MAX_NREQ-1:0] valid,
      input logic [GW-1:0]       last,
      input int                  nreq,
      input logic                prio0
   );
      logic [GW-1:0] pick;
      logic [GW:0]   idx;
      pick = last;
      for (int k = MAX_NREQ; k >= 1; k--) begin
         if (k <= nreq) begin
            idx = {1'b0, last} + (GW+1)'(k);
            if (idx >= (GW+1)'(nreq)) idx = idx - (GW+1)'(nreq);
            if (valid[idx[GW-1:0]]) pick = idx[GW-1:0];
         end
      end
      if (prio0 && valid[0]) pick = '0;
      return pick;
   endfunction

endpackage

// File: rtl/sdram_req_arb_if.sv
// Requester bus plus toggle-handshake SDRAM port of the arbiter.
// master = arbiter side, slave = requesters and SDRAM controller side.
interface sdram_req_arb_if #(
   parameter int NREQ = 3,
   parameter int AW   = 23
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_we;
   logic [NREQ*AW-1:0] req_a;
   logic [NREQ*2-1:0]  req_ds;
   logic [NREQ*16-1:0] req_d;
   logic [NREQ-1:0]    done;
   logic [15:0]        rd_q;
   logic               busy;

   logic               port_req;
   logic               port_ack;
   logic               port_we;
   logic [AW-1:0]      port_a;
   logic [1:0]         port_ds;
   logic [15:0]        port_d;
   logic [15:0]        port_q;

   modport master (
      input  req_valid, req_we, req_a, req_ds, req_d, port_ack, port_q,
      output done, rd_q, busy, port_req, port_we, port_a, port_ds, port_d
   );

   modport slave (
      output req_valid, req_we, req_a, req_ds, req_d, port_ack, port_q,
      input  done, rd_q, busy, port_req, port_we, port_a, port_ds, port_d
   );
endinterface

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin selector with optional strict priority for index 0.
module sdram_rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int PRIO0 = 1
)(
   input  logic [NREQ-1:0] i_valid,
   input  logic [GW-1:0]   i_last,
   output logic [GW-1:0]   o_winner,
   output logic            o_any
);

   logic [MAX_NREQ-1:0] w_validExt;

   always_comb begin
      w_validExt               = '0;
      w_validExt[NREQ-1:0]     = i_valid;
      o_winner                 = rr_pick(w_validExt, i_last, NREQ, PRIO0 != 0);
      o_any                    = |i_valid;
   end

endmodule

// File: rtl/sdram_req_arb.sv
// Shares one toggle-handshake SDRAM request port between NREQ level requesters.
// Define SDRAM_REQ_ARB_POSTWR_EN to acknowledge writes at grant instead of at ack.
module sdram_req_arb
   import sdram_arb_pkg::*;
#(
   parameter int NREQ  = 3,
   parameter int AW    = 23,
   parameter int PRIO0 = 1
)(
   input logic              clk,
   input logic              init_n,
   sdram_req_arb_if.master  bus
);

   arb_state_t       r_state;
   logic [GW-1:0]    r_grant;
   logic [GW-1:0]    r_lastGrant;
   logic [NREQ-1:0]  r_done;
   logic [DW-1:0]    r_rdQ;
   logic             r_portReq;
   logic             r_portWe;
   logic [AW-1:0]    r_portA;
   logic [DSW-1:0]   r_portDs;
   logic [DW-1:0]    r_portD;

   logic [GW-1:0]    w_winner;
   logic             w_any;
   logic [NREQ-1:0]  w_grantOh;
   logic             w_selWe;
   logic [AW-1:0]    w_selA;
   logic [DSW-1:0]   w_selDs;
   logic [DW-1:0]    w_selD;
`ifdef SDRAM_REQ_ARB_POSTWR_EN
   logic [NREQ-1:0]  w_winOh;
   logic             r_posted;
`endif

   sdram_rr_pick #(
      .NREQ  (NREQ),
      .PRIO0 (PRIO0)
   ) u_pick (
      .i_valid  (bus.req_valid),
      .i_last   (r_lastGrant),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   // Mux the winner's request fields and decode grant indices to one-hot.
   always_comb begin
      w_selWe   = 1'b0;
      w_selA    = '0;
      w_selDs   = '0;
      w_selD    = '0;
      w_grantOh = '0;
`ifdef SDRAM_REQ_ARB_POSTWR_EN
      w_winOh   = '0;
`endif
      for (int i = 0; i < NREQ; i++) begin
         w_grantOh[i] = (r_grant == GW'(i));
`ifdef SDRAM_REQ_ARB_POSTWR_EN
         w_winOh[i]   = (w_winner == GW'(i));
`endif
         if (w_winner == GW'(i)) begin
            w_selWe = bus.req_we[i];
            w_selA  = bus.req_a[i*AW +: AW];
            w_selDs = bus.req_ds[i*DSW +: DSW];
            w_selD  = bus.req_d[i*DW +: DW];
         end
      end
   end

   // HOLD gives the finished requester a cycle to drop valid before re-arbitration.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         r_state     <= IDLE;
         r_grant     <= '0;
         r_lastGrant <= GW'(NREQ-1);
         r_done      <= '0;
         r_rdQ       <= '0;
         r_portReq   <= 1'b0;
         r_portWe    <= 1'b0;
         r_portA     <= '0;
         r_portDs    <= '0;
         r_portD     <= '0;
`ifdef SDRAM_REQ_ARB_POSTWR_EN
         r_posted    <= 1'b0;
`endif
      end else begin
         r_done <= '0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grant   <= w_winner;
                  r_portWe  <= w_selWe;
                  r_portA   <= w_selA;
                  r_portDs  <= w_selDs;
                  r_portD   <= w_selD;
                  r_portReq <= ~r_portReq;
                  r_state   <= WAIT;
`ifdef SDRAM_REQ_ARB_POSTWR_EN
                  r_posted  <= w_selWe;
                  if (w_selWe) r_done <= w_winOh;
`endif
               end
            end
            WAIT: begin
               if (bus.port_ack == r_portReq) begin
                  if (!r_portWe) r_rdQ <= bus.port_q;
`ifdef SDRAM_REQ_ARB_POSTWR_EN
                  if (!r_posted) r_done <= w_grantOh;
`else
                  r_done <= w_grantOh;
`endif
                  r_lastGrant <= r_grant;
                  r_state     <= HOLD;
               end
            end
            HOLD:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.done     = r_done;
   assign bus.rd_q     = r_rdQ;
   assign bus.busy     = (r_state != IDLE);
   assign bus.port_req = r_portReq;
   assign bus.port_we  = r_portWe;
   assign bus.port_a   = r_portA;
   assign bus.port_ds  = r_portDs;
   assign bus.port_d   = r_portD;

endmodule

// File: doc/sdram_req_arb.md
Name: sdram_req_arb

Overview:
Arbiter that shares one toggle-handshake SDRAM request port (req/ack/we/a/ds/d/q, 23-bit word address) between NREQ level-handshake requesters. Typical requesters are the ROM downloader, NVRAM/hiscore save and a debug/CPU slow path. It sits between those clients and the sdram controller's generic request port. It serialises accesses, holds one access in flight, and returns read data and a one-cycle completion pulse to the granted requester.

Parameters:
NREQ, 3, number of requesters (2..8)
AW, 23, word address width (byte address bits [AW:1])
PRIO0, 1, 1 = requester 0 has strict priority over all others; 0 = all round-robin

Ports:
clk  in  1  system/SDRAM clock
init_n  in  1  asynchronous active-low reset; asserted together with the sdram controller's init_n
req_valid  in  NREQ  per-requester level request; held, with its fields stable, until its done bit pulses
req_we  in  NREQ  1 = write
req_a  in  NREQ*AW  word addresses, requester i at [i*AW +: AW]
req_ds  in  NREQ*2  byte selects, {upper, lower}
req_d  in  NREQ*16  write data
done  out  NREQ  one-cycle completion pulse per requester
rd_q  out  16  read data, valid from the done cycle until the next read completes
busy  out  1  access in flight (state != IDLE)
port_req  out  1  toggle request to SDRAM
port_ack  in  1  SDRAM ack; equal to port_req when the access is complete
port_we  out  1  write enable to SDRAM
port_a  out  AW  address to SDRAM
port_ds  out  2  byte selects to SDRAM
port_d  out  16  write data to SDRAM
port_q  in  16  read data from SDRAM, valid when port_ack == port_req

Behaviour:
- Reset values (async on init_n low): state=IDLE, port_req=0, port_we=0, port_a=0, port_ds=0, port_d=0, done=0, rd_q=0, busy=0, last_grant=NREQ-1 (first round-robin grant goes to requester 0).
- Reset mid-access abandons the access. Both blocks reset together, so port_req and port_ack both start at 0.
- States: IDLE, WAIT, HOLD.
- IDLE, if any req_valid:
  - Select a winner. With PRIO0=1 and req_valid[0] set, the winner is 0. Otherwise the winner is the first valid index searching from last_grant+1, wrapping modulo NREQ.
  - Register grant, port_we/a/ds/d from the winner's fields, toggle port_req, go to WAIT. The SDRAM sees the request on the edge after req_valid is first sampled.
- WAIT:
  - Complete when port_ack == port_req.
  - On completion, if the access was a read, rd_q <= port_q.
  - done[grant] <= 1 for exactly one cycle, last_grant <= grant, go to HOLD.
  - No timeout; the arbiter waits indefinitely.
- HOLD: one cycle with all req_valid ignored, giving the requester time to drop valid after done. Then go to IDLE. A requester still asserting valid in IDLE is treated as a new access, so back-to-back streaming is allowed.
- Throughput: 3 cycles of arbiter overhead plus the SDRAM latency per access.
- A requester changing its fields while valid and ungranted is legal; fields are sampled only at grant.
- With PRIO0=0, no requester is starved: the maximum wait is NREQ-1 accesses.
- With PRIO0=1, requesters 1..NREQ-1 may starve while requester 0 streams. This is accepted for ROM download.
- A requester dropping valid before done is a protocol violation. The access still completes and done still pulses.
- port_ack toggling while IDLE is ignored.

Optional Feature:
SDRAM_REQ_ARB_POSTWR_EN
- Defined: writes are posted.
  - done[i] pulses the cycle after a write is granted in IDLE, without waiting for the ack.
  - The state machine stays in WAIT until the ack, and further requests queue as normal.
  - rd_q is unaffected by writes.
- Undefined: writes complete with done only after the ack, identical to reads.

Decomposition:
- Package sdram_arb_pkg: state enum (IDLE/WAIT/HOLD), localparam widths, a function rr_pick(valid, last, prio0) returning the winner index.
- One natural sub-module: sdram_rr_pick, a combinational round-robin/priority selector with NREQ/PRIO0 parameters. It is reused by the sprite-fetch scheduler.

Test Plan:
- Reset, then a single read, requester 1 at a=0x00_1234, stub SDRAM acks 6 cycles after the toggle and returns 0xBEEF:
  - port_req goes 0->1 one cycle after valid, with port_a=0x001234.
  - done[1] pulses once and rd_q=0xBEEF.
- All three requesters valid continuously, PRIO0=0: grant order 0,1,2,0,1,2. Each done is one cycle wide, separated by WAIT+HOLD.
- PRIO0=1, requesters 0 and 2 valid continuously:
  - Only requester 0 is granted while it holds valid.
  - Dropping valid0 yields requester 2 on the next IDLE.
- Write, requester 0, ds=2'b10, d=0x5A00:
  - port_we=1, port_ds=2'b10, port_d=0x5A00.
  - With POSTWR_EN, done[0] pulses before the ack; without it, after the ack.
  - rd_q is unchanged.
- init_n pulsed low during WAIT:
  - All outputs return to reset values asynchronously.
  - After release, a new read to 0x000010 from requester 2 completes normally.
- port_ack toggled spuriously in IDLE: no done pulse and no state change.
